csr_irq_unit: RTL and testbench
===============================

Name: csr_irq_unit

Overview:
- Parametrised machine-mode CSR and interrupt unit for the 5-stage RV32 pipeline; successor to the single-interrupt CSR block.
- Supports NUM_IRQ level-sensitive interrupt lines with fixed priority, per-line enables, and direct or vectored mtvec.
- Provides 64-bit mcycle/minstret counters, CSR read-modify-write, mret, and a WFI sleep FSM.
- Sits beside the regfile: CSR reads in ID, CSR writes and retire info from WB; trap/mret redirects go to the PC mux.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..16); line i maps to mie/mip bit 16+i and cause code 16+i.
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
- VECTORED_EN, 1, 0 forces mtvec.MODE to read 0 (direct only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_i  in  NUM_IRQ  level interrupt requests.
- csr_raddr_i  in  12  ID-stage read address.
- csr_rdata_o  out  32  combinational read data.
- illegal_csr_o  out  1  csr_raddr_i not implemented (combinational).
- csr_op_i  in  2  WB op: 00 none, 01 write, 10 set, 11 clear.
- csr_waddr_i  in  12  WB write address.
- csr_src_i  in  32  rs1 value or zimm.
- instr_retire_i  in  1  one instruction retired this cycle.
- epc_i  in  32  PC to resume at when a trap is taken.
- trap_ok_i  in  1  pipeline can accept a redirect this cycle.
- mret_i  in  1  mret executing.
- wfi_i  in  1  wfi in ID.
- trap_o  out  1  take interrupt this cycle.
- trap_pc_o  out  32  handler address, valid with trap_o.
- mret_pc_o  out  32  current mepc.
- wfi_stall_o  out  1  hold PC and IF/ID.

Behaviour:
- Reset values: mstatus, mie, mepc, mcause and all counters are 0; mtvec = MTVEC_RESET; mip = 0; FSM = RUN; trap_o = 0; wfi_stall_o = 0.
- Addresses: mstatus 0x300 (MIE bit3, MPIE bit7; other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82. Any other address reads 0 and raises illegal_csr_o.
- mip[16+i] is irq_i[i] registered, giving 1 cycle of latency. mip is read-only; writes to it are ignored. Unimplemented mie bits read 0.
- RMW result: write = src; set = old | src; clear = old & ~src. The result is committed at the clock edge.
- mepc[1:0] is forced to 0. mtvec[1] is forced to 0.
- pend = mip & mie. sel = lowest index i with pend[16+i] set.
- trap_o = mstatus.MIE & |pend & trap_ok_i & ~mret_i (combinational).
- trap_pc_o:
  - Direct mode: {mtvec[31:2], 2'b00}.
  - Vectored mode: {mtvec[31:2], 2'b00} + 4*(16+sel).
- On a trap edge: mepc <= epc_i; mcause <= {1'b1, 31'(16+sel)}; MPIE <= MIE; MIE <= 0.
- On an mret edge (no trap): MIE <= MPIE; MPIE <= 1.
- Same-cycle CSR write and trap: hardware updates to mstatus, mepc and mcause win; writes to other CSRs still apply.
- Same-cycle mret and irq: the trap is suppressed that cycle and is re-evaluated next cycle with the restored MIE.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire_i = 1.
  - A software write to either half of a counter replaces that half and suppresses the increment that cycle.
  - Carries propagate from the low half to the high half; at all-ones the counter wraps to 0.
- WFI FSM, states RUN and SLEEP:
  - RUN -> SLEEP when wfi_i & ~|pend.
  - SLEEP -> RUN when |pend. The wake condition ignores mstatus.MIE.
  - wfi_stall_o = (state==SLEEP) | (wfi_i & ~|pend).
  - If MIE = 1 on wake, trap_o may assert in the same cycle as the wake.
- A reset assertion mid-sleep or mid-trap returns all state to the reset values immediately (asynchronous).

Decomposition:
- Shared package csr_pkg holds:
  - CSR address localparams.
  - mstatus bit indices.
  - The csr_op_e enum.
  - The interrupt cause-code base (16).
  - The fsm_e enum {RUN, SLEEP}.
- One sub-module, irq_prio_enc: a parametrised NUM_IRQ lowest-index priority encoder producing a valid bit and an index.

Test Plan:
- Reset mid-sleep, with wfi_i=1 and pending low, then reset pulse -> wfi_stall_o=0, FSM=RUN, mtvec=MTVEC_RESET, mcycle=0.
- Set mtvec=0x100 direct, mie bit17, MIE=1, raise irq_i[1] at cycle k -> trap_o=1 at k+1 with trap_pc_o=0x100; mcause=0x8000_0011; mepc=epc_i; MIE=0; MPIE=1.
- Vectored mode, mtvec=0x201, irq_i=4'b1010 with all lines enabled -> sel=1, trap_pc_o=0x200+4*17=0x244; then mret -> MIE=1 and mret_pc_o=mepc.
- Set with op=10, src=0x8 on mstatus from 0 -> MIE=1; clear with op=11, src=0x8 -> MIE=0; write to mip=0xFFFF_FFFF -> mip unchanged; read of 0x7C0 -> rdata=0, illegal_csr_o=1.
- wfi_i=1 with MIE=0 and mie bit16 set; irq_i[0] rises after 10 cycles -> wfi_stall_o held high, drops in the cycle after mip updates, trap_o stays 0.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle reads mcycle=0, mcycleh=1; trap edge concurrent with a mepc write of 0x40 -> mepc=epc_i.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR and interrupt unit.
// Addresses, mstatus bit positions, op/state enums and read helpers.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_SET,
    OP_CLEAR
  } csr_op_e;

  typedef enum logic {
    RUN,
    SLEEP
  } fsm_e;

  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mip;
    logic [63:0] mcycle;
    logic [63:0] minstret;
  } csr_view_t;

  function automatic logic [31:0] csr_rmw(
    csr_op_e     op,
    logic [31:0] old,
    logic [31:0] src
  );
    case (op)
      OP_WRITE: csr_rmw = src;
      OP_SET:   csr_rmw = old | src;
      OP_CLEAR: csr_rmw = old & ~src;
      default:  csr_rmw = old;
    endcase
  endfunction

  function automatic logic csr_legal(logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP,
      CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MINSTRET, CSR_MINSTRETH:
        csr_legal = 1'b1;
      default: csr_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_read(
    logic [11:0] a,
    csr_view_t   v
  );
    case (a)
      CSR_MSTATUS:   csr_read = v.mstatus;
      CSR_MIE:       csr_read = v.mie;
      CSR_MTVEC:     csr_read = v.mtvec;
      CSR_MEPC:      csr_read = v.mepc;
      CSR_MCAUSE:    csr_read = v.mcause;
      CSR_MIP:       csr_read = v.mip;
      CSR_MCYCLE:    csr_read = v.mcycle[31:0];
      CSR_MCYCLEH:   csr_read = v.mcycle[63:32];
      CSR_MINSTRET:  csr_read = v.minstret[31:0];
      CSR_MINSTRETH: csr_read = v.minstret[63:32];
      default:       csr_read = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Index is 4 bits wide to cover up to 16 interrupt lines.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with prioritised level interrupts,
// 64-bit counters, mret handling and a WFI sleep FSM.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          VECTORED_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [11:0]        csr_raddr_i,
  output logic [31:0]        csr_rdata_o,
  output logic               illegal_csr_o,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_waddr_i,
  input  logic [31:0]        csr_src_i,
  input  logic               instr_retire_i,
  input  logic [31:0]        epc_i,
  input  logic               trap_ok_i,
  input  logic               mret_i,
  input  logic               wfi_i,
  output logic               trap_o,
  output logic [31:0]        trap_pc_o,
  output logic [31:0]        mret_pc_o,
  output logic               wfi_stall_o
);

  // mtvec bit 1 is reserved; bit 0 only survives with vectoring
  localparam logic [31:0] MTVEC_MASK =
    (VECTORED_EN != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic [NUM_IRQ-1:0] mip_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [NUM_IRQ-1:0] pend;
  logic               mie_b;
  logic               mpie_b;
  logic [31:0]        mtvec_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mcause_q;
  logic [63:0]        mcycle_q;
  logic [63:0]        minstret_q;
  fsm_e               state_q;

  logic               pend_any;
  logic [3:0]         sel;
  csr_view_t          view;
  csr_op_e            op;
  logic               wen;
  logic [31:0]        wold;
  logic [31:0]        wdata;
  logic [31:0]        base;
  logic [31:0]        vec_off;

  assign pend = mip_q & mie_q;

  irq_prio_enc #(
    .N(NUM_IRQ)
  ) u_enc (
    .req  (pend),
    .valid(pend_any),
    .idx  (sel)
  );

  always_comb begin
    view         = '0;
    view.mstatus[MSTATUS_MIE]  = mie_b;
    view.mstatus[MSTATUS_MPIE] = mpie_b;
    view.mie     = 32'(mie_q) << IRQ_BASE;
    view.mtvec   = mtvec_q;
    view.mepc    = mepc_q;
    view.mcause  = mcause_q;
    view.mip     = 32'(mip_q) << IRQ_BASE;
    view.mcycle  = mcycle_q;
    view.minstret = minstret_q;
  end

  assign csr_rdata_o   = csr_read(csr_raddr_i, view);
  assign illegal_csr_o = ~csr_legal(csr_raddr_i);

  assign op    = csr_op_e'(csr_op_i);
  assign wen   = (op != OP_NONE);
  assign wold  = csr_read(csr_waddr_i, view);
  assign wdata = csr_rmw(op, wold, csr_src_i);

  assign trap_o = mie_b & pend_any & trap_ok_i & ~mret_i;

  assign base    = {mtvec_q[31:2], 2'b00};
  assign vec_off = (32'(IRQ_BASE) + 32'(sel)) << 2;
  assign trap_pc_o = mtvec_q[0] ? base + vec_off : base;
  assign mret_pc_o = mepc_q;

  assign wfi_stall_o = (state_q == SLEEP) |
                       (wfi_i & ~pend_any);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mip_q      <= '0;
      mie_q      <= '0;
      mie_b      <= 1'b0;
      mpie_b     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      state_q    <= RUN;
    end else begin
      mip_q <= irq_i;

      if (wen && csr_waddr_i == CSR_MIE)
        mie_q <= wdata[IRQ_BASE +: NUM_IRQ];
      if (wen && csr_waddr_i == CSR_MTVEC)
        mtvec_q <= wdata & MTVEC_MASK;

      // hardware trap/mret updates take precedence over software
      if (trap_o) begin
        mpie_b <= mie_b;
        mie_b  <= 1'b0;
      end else if (mret_i) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
      end else if (wen && csr_waddr_i == CSR_MSTATUS) begin
        mie_b  <= wdata[MSTATUS_MIE];
        mpie_b <= wdata[MSTATUS_MPIE];
      end

      if (trap_o)
        mepc_q <= epc_i & 32'hFFFF_FFFC;
      else if (wen && csr_waddr_i == CSR_MEPC)
        mepc_q <= wdata & 32'hFFFF_FFFC;

      if (trap_o)
        mcause_q <= {1'b1, 31'(IRQ_BASE) + 31'(sel)};
      else if (wen && csr_waddr_i == CSR_MCAUSE)
        mcause_q <= wdata;

      if (wen && csr_waddr_i == CSR_MCYCLE)
        mcycle_q[31:0] <= wdata;
      else if (wen && csr_waddr_i == CSR_MCYCLEH)
        mcycle_q[63:32] <= wdata;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (wen && csr_waddr_i == CSR_MINSTRET)
        minstret_q[31:0] <= wdata;
      else if (wen && csr_waddr_i == CSR_MINSTRETH)
        minstret_q[63:32] <= wdata;
      else if (instr_retire_i)
        minstret_q <= minstret_q + 64'd1;

      unique case (state_q)
        RUN:   if (wfi_i && !pend_any) state_q <= SLEEP;
        SLEEP: if (pend_any) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed-vector bench for csr_irq_unit.
// Inputs change on negedge; outputs are checked before the next posedge.
module tb_csr_irq_unit;

  localparam logic [31:0] MTV_RST = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        illegal_csr_o;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_src_i;
  logic        instr_retire_i;
  logic [31:0] epc_i;
  logic        trap_ok_i;
  logic        mret_i;
  logic        wfi_i;
  logic        trap_o;
  logic [31:0] trap_pc_o;
  logic [31:0] mret_pc_o;
  logic        wfi_stall_o;

  int vectors;
  int miscompares;

  csr_irq_unit #(
    .NUM_IRQ    (4),
    .MTVEC_RESET(MTV_RST),
    .VECTORED_EN(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_i         (irq_i),
    .csr_raddr_i   (csr_raddr_i),
    .csr_rdata_o   (csr_rdata_o),
    .illegal_csr_o (illegal_csr_o),
    .csr_op_i      (csr_op_i),
    .csr_waddr_i   (csr_waddr_i),
    .csr_src_i     (csr_src_i),
    .instr_retire_i(instr_retire_i),
    .epc_i         (epc_i),
    .trap_ok_i     (trap_ok_i),
    .mret_i        (mret_i),
    .wfi_i         (wfi_i),
    .trap_o        (trap_o),
    .trap_pc_o     (trap_pc_o),
    .mret_pc_o     (mret_pc_o),
    .wfi_stall_o   (wfi_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [11:0] a,
                    input logic [31:0] exp);
    csr_raddr_i = a;
    #1;
    chk(tag, csr_rdata_o, exp);
  endtask

  task automatic csr_wr(input logic [11:0] a,
                        input logic [1:0] op,
                        input logic [31:0] src);
    csr_waddr_i = a;
    csr_op_i    = op;
    csr_src_i   = src;
    @(negedge clk);
    csr_op_i    = 2'b00;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    irq_i          = '0;
    csr_raddr_i    = '0;
    csr_op_i       = '0;
    csr_waddr_i    = '0;
    csr_src_i      = '0;
    instr_retire_i = 1'b0;
    epc_i          = '0;
    trap_ok_i      = 1'b0;
    mret_i         = 1'b0;
    wfi_i          = 1'b0;

    #1;
    chk("rst_trap", 32'(trap_o), 32'd0);
    chk("rst_stall", 32'(wfi_stall_o), 32'd0);
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset while asleep
    csr_wr(12'h305, 2'b01, 32'h0000_0057);
    rd("mtvec_b1", 12'h305, 32'h0000_0055);
    wfi_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sleep_stall", 32'(wfi_stall_o), 32'd1);
    #1;
    reset = 1'b1;
    wfi_i = 1'b0;
    #1;
    chk("arst_stall", 32'(wfi_stall_o), 32'd0);
    rd("arst_mtvec", 12'h305, MTV_RST);
    rd("arst_mcycle", 12'hB00, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_fsm_run", 32'(wfi_stall_o), 32'd0);

    // direct-mode trap on line 1
    trap_ok_i = 1'b1;
    epc_i     = 32'h1234_5678;
    csr_wr(12'h305, 2'b01, 32'h0000_0100);
    csr_wr(12'h304, 2'b01, 32'h0002_0000);
    csr_wr(12'h300, 2'b01, 32'h0000_0008);
    irq_i = 4'b0010;
    #1;
    chk("irq_lat0", 32'(trap_o), 32'd0);
    @(negedge clk);
    #1;
    chk("dir_trap", 32'(trap_o), 32'd1);
    chk("dir_pc", trap_pc_o, 32'h0000_0100);
    irq_i = 4'b0000;
    @(negedge clk);
    #1;
    chk("dir_trap_off", 32'(trap_o), 32'd0);
    rd("dir_mcause", 12'h342, 32'h8000_0011);
    rd("dir_mepc", 12'h341, 32'h1234_5678);
    rd("dir_mstatus", 12'h300, 32'h0000_0080);

    // vectored trap, priority, then mret
    csr_wr(12'h305, 2'b01, 32'h0000_0201);
    rd("vec_mtvec", 12'h305, 32'h0000_0201);
    csr_wr(12'h304, 2'b01, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h000F_0000);
    epc_i = 32'h0000_2000;
    irq_i = 4'b1010;
    @(negedge clk);
    #1;
    chk("mie0_notrap", 32'(trap_o), 32'd0);
    csr_wr(12'h300, 2'b10, 32'h0000_0008);
    #1;
    chk("vec_trap", 32'(trap_o), 32'd1);
    chk("vec_pc", trap_pc_o, 32'h0000_0244);
    irq_i = 4'b0000;
    @(negedge clk);
    rd("vec_mcause", 12'h342, 32'h8000_0011);
    rd("vec_mepc", 12'h341, 32'h0000_2000);
    rd("vec_mstatus", 12'h300, 32'h0000_0080);
    mret_i = 1'b1;
    #1;
    chk("mret_pc", mret_pc_o, 32'h0000_2000);
    @(negedge clk);
    mret_i = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_0088);
    chk("mret_notrap", 32'(trap_o), 32'd0);

    // mret and pending irq in the same cycle
    trap_ok_i = 1'b0;
    irq_i     = 4'b0001;
    @(negedge clk);
    #1;
    chk("trap_ok_gate", 32'(trap_o), 32'd0);
    trap_ok_i = 1'b1;
    mret_i    = 1'b1;
    #1;
    chk("mret_supp", 32'(trap_o), 32'd0);
    @(negedge clk);
    mret_i = 1'b0;
    #1;
    chk("post_mret_trap", 32'(trap_o), 32'd1);
    chk("post_mret_pc", trap_pc_o, 32'h0000_0240);
    irq_i = 4'b0000;
    @(negedge clk);
    rd("l0_mcause", 12'h342, 32'h8000_0010);

    // set/clear on mstatus, mip read-only, illegal address
    csr_wr(12'h300, 2'b11, 32'h0000_0088);
    rd("clr_all", 12'h300, 32'h0000_0000);
    csr_wr(12'h300, 2'b10, 32'h0000_0008);
    rd("set_mie", 12'h300, 32'h0000_0008);
    csr_wr(12'h300, 2'b11, 32'h0000_0008);
    rd("clr_mie", 12'h300, 32'h0000_0000);
    csr_wr(12'h344, 2'b01, 32'hFFFF_FFFF);
    rd("mip_ro", 12'h344, 32'h0000_0000);
    rd("illegal_rd", 12'h7C0, 32'h0000_0000);
    chk("illegal_flag", 32'(illegal_csr_o), 32'd1);
    rd("legal_rd", 12'h300, 32'h0000_0000);
    chk("legal_flag", 32'(illegal_csr_o), 32'd0);

    // WFI with MIE=0: wake without trapping
    csr_wr(12'h304, 2'b01, 32'h0001_0000);
    wfi_i = 1'b1;
    #1;
    chk("wfi_enter", 32'(wfi_stall_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (i == 4 || i == 9)
        chk("wfi_hold", 32'(wfi_stall_o), 32'd1);
    end
    irq_i = 4'b0001;
    #1;
    chk("wfi_irq_in", 32'(wfi_stall_o), 32'd1);
    @(negedge clk);
    #1;
    chk("wfi_mip_upd", 32'(wfi_stall_o), 32'd1);
    chk("wfi_no_trap", 32'(trap_o), 32'd0);
    @(negedge clk);
    #1;
    chk("wfi_woke", 32'(wfi_stall_o), 32'd0);
    chk("wfi_no_trap2", 32'(trap_o), 32'd0);
    wfi_i = 1'b0;
    irq_i = 4'b0000;
    @(negedge clk);

    // counter carry and write suppression
    csr_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 2'b01, 32'h0000_0000);
    rd("cyc_lo_held", 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_hi_wr", 12'hB80, 32'h0000_0000);
    @(negedge clk);
    rd("cyc_lo_wrap", 12'hB00, 32'h0000_0000);
    rd("cyc_hi_carry", 12'hB80, 32'h0000_0001);
    instr_retire_i = 1'b1;
    csr_wr(12'hB02, 2'b01, 32'h0000_0005);
    rd("ret_wr_supp", 12'hB02, 32'h0000_0005);
    @(negedge clk);
    @(negedge clk);
    instr_retire_i = 1'b0;
    rd("ret_count", 12'hB02, 32'h0000_0007);
    @(negedge clk);
    rd("ret_idle", 12'hB02, 32'h0000_0007);

    // trap wins over a concurrent mepc write
    trap_ok_i = 1'b0;
    csr_wr(12'h300, 2'b10, 32'h0000_0008);
    irq_i = 4'b0001;
    @(negedge clk);
    #1;
    chk("gate_off", 32'(trap_o), 32'd0);
    trap_ok_i   = 1'b1;
    epc_i       = 32'h0000_3000;
    csr_waddr_i = 12'h341;
    csr_op_i    = 2'b01;
    csr_src_i   = 32'h0000_0040;
    #1;
    chk("race_trap", 32'(trap_o), 32'd1);
    @(negedge clk);
    csr_op_i = 2'b00;
    irq_i    = 4'b0000;
    rd("race_mepc", 12'h341, 32'h0000_3000);
    rd("race_mcause", 12'h342, 32'h8000_0010);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
